// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared op encodings, FSM states and op-decode helpers for the MEM stage
package mem_access_unit_pkg;
  localparam logic [7:0] EXE_NOP_OP   = 8'h00;
  localparam logic [7:0] EXE_ADD_OP   = 8'h01;
  localparam logic [7:0] EXE_LD_B_OP  = 8'h20;
  localparam logic [7:0] EXE_LD_H_OP  = 8'h21;
  localparam logic [7:0] EXE_LD_W_OP  = 8'h22;
  localparam logic [7:0] EXE_LD_BU_OP = 8'h24;
  localparam logic [7:0] EXE_LD_HU_OP = 8'h25;
  localparam logic [7:0] EXE_ST_B_OP  = 8'h28;
  localparam logic [7:0] EXE_ST_H_OP  = 8'h29;
  localparam logic [7:0] EXE_ST_W_OP  = 8'h2a;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} mem_size_e;
  function automatic mem_size_e op_size(input logic [7:0] op);
    return (op == EXE_LD_B_OP || op == EXE_LD_BU_OP || op == EXE_ST_B_OP) ? SZ_B :
           (op == EXE_LD_H_OP || op == EXE_LD_HU_OP || op == EXE_ST_H_OP) ? SZ_H :
           (op == EXE_LD_W_OP || op == EXE_ST_W_OP) ? SZ_W : SZ_NONE;
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op == EXE_ST_B_OP || op == EXE_ST_H_OP || op == EXE_ST_W_OP;
  endfunction
  function automatic logic is_unsigned(input logic [7:0] op);
    return op == EXE_LD_BU_OP || op == EXE_LD_HU_OP;
  endfunction
endpackage

// File: rtl/mem_access_unit_align.sv
// mem_access_unit_align: byte enables, store-data replication and load extraction/extension
// Ports: op_i/addr_i select size and lane; st_data_i store operand; rdata_i memory read word;
//        be_o byte enables, wdata_o replicated store word, ldata_o extended load result.
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  mem_size_e   sz;
  logic        sx;
  logic [7:0]  b;
  logic [15:0] h;
  assign sz = op_size(op_i);
  assign sx = ~is_unsigned(op_i);
  assign b = rdata_i[{addr_i, 3'b000} +: 8];
  assign h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign be_o = sz == SZ_W ? 4'hf : sz == SZ_H ? (addr_i[1] ? 4'hc : 4'h3) : 4'b0001 << addr_i;
  assign wdata_o = sz == SZ_W ? st_data_i : sz == SZ_H ? {2{st_data_i[15:0]}} : {4{st_data_i[7:0]}};
  assign ldata_o = sz == SZ_W ? rdata_i : sz == SZ_H ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage performing byte/half/word loads and stores over a req/ack port
// Ports: clk/rst (async, active-low); EX bundle in (aluop_i, mem_addr_i, reg2_i, wd_i/wreg_i/wdata_i,
//        inst_valid_i/inst_pc_i/excepttype_i, flush_i); WB bundle out (wd_o/wreg_o/wdata_o,
//        inst_valid_o/inst_pc_o/excepttype_o); ale_o misalignment; stallreq_o holds IF..EX;
//        data_* memory port with data_ack_i/data_rdata_i completion.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_pc_i,
  input  logic [1:0]  excepttype_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_pc_o,
  output logic [1:0]  excepttype_o,
  output logic        ale_o,
  output logic        stallreq_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_ack_i,
  input  logic [31:0] data_rdata_i
);
  logic [1:0]  state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] addr_q, st_q, rdata_q;
  logic [4:0]  wd_q;
  logic        drop_q, drop_d;
  mem_size_e   sz;
  logic        is_mem, mis, go, in_req;
  logic [3:0]  be;
  logic [31:0] st_fmt, ld_fmt;
  assign sz = op_size(aluop_i);
  assign is_mem = inst_valid_i & (sz != SZ_NONE);
  assign mis = (sz == SZ_H & mem_addr_i[0]) | (sz == SZ_W & |mem_addr_i[1:0]);
  assign go = state_q == S_IDLE & is_mem & ~flush_i & ~|excepttype_i & ~mis;
  assign in_req = state_q == S_REQ;
  assign state_d = state_q == S_IDLE ? (go ? S_REQ : S_IDLE) :
                   in_req ? (data_ack_i ? S_DONE : S_REQ) : S_IDLE;
  // A flush seen while the request is in flight cannot cancel it; remember it for DONE.
  assign drop_d = go ? 1'b0 : drop_q | (in_req & flush_i);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      st_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (go) begin
        op_q   <= aluop_i;
        addr_q <= mem_addr_i;
        st_q   <= reg2_i;
        wd_q   <= wd_i;
      end
      if (in_req & data_ack_i) rdata_q <= data_rdata_i;
    end
  end
  mem_access_unit_align u_align (
    .op_i      (op_q),
    .addr_i    (addr_q[1:0]),
    .st_data_i (st_q),
    .rdata_i   (rdata_q),
    .be_o      (be),
    .wdata_o   (st_fmt),
    .ldata_o   (ld_fmt)
  );
  // Port is driven only from latched state, so it stays stable for the whole REQ phase.
  assign data_req_o   = in_req;
  assign data_we_o    = in_req & is_store(op_q);
  assign data_be_o    = in_req ? be : 4'h0;
  assign data_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign data_wdata_o = in_req ? st_fmt : 32'h0;
  always_comb begin
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    inst_valid_o = inst_valid_i;
    inst_pc_o    = inst_pc_i;
    excepttype_o = excepttype_i;
    ale_o        = 1'b0;
    stallreq_o   = 1'b0;
    if (state_q == S_IDLE) begin
      ale_o      = is_mem & ~flush_i & ~|excepttype_i & mis;
      stallreq_o = go;
      wreg_o     = wreg_i & ~flush_i & ~is_mem;
    end else if (in_req) begin
      stallreq_o = 1'b1;
      wreg_o     = 1'b0;
    end else begin
      wd_o         = wd_q;
      wreg_o       = ~is_store(op_q) & ~drop_q;
      wdata_o      = ld_fmt;
      inst_valid_o = inst_valid_i & ~drop_q;
    end
    if (!rst) begin
      wd_o         = '0;
      wreg_o       = 1'b0;
      wdata_o      = '0;
      inst_valid_o = 1'b0;
      inst_pc_o    = '0;
      excepttype_o = '0;
      ale_o        = 1'b0;
      stallreq_o   = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for the MEM stage with a req/ack memory responder
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic        clk, rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, inst_pc_i, data_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, inst_valid_i, flush_i, data_ack_i;
  logic [1:0]  excepttype_i;
  logic [4:0]  wd_o;
  logic        wreg_o, inst_valid_o, ale_o, stallreq_o, data_req_o, data_we_o;
  logic [31:0] wdata_o, inst_pc_o, data_addr_o, data_wdata_o;
  logic [1:0]  excepttype_o;
  logic [3:0]  data_be_o;
  typedef struct {
    logic        wreg;
    logic        valid;
    logic        ale;
    logic [31:0] wdata;
    int          stall;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .inst_valid_i(inst_valid_i),
    .inst_pc_i(inst_pc_i), .excepttype_i(excepttype_i), .flush_i(flush_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .inst_valid_o(inst_valid_o),
    .inst_pc_o(inst_pc_o), .excepttype_o(excepttype_o), .ale_o(ale_o), .stallreq_o(stallreq_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_ack_i(data_ack_i), .data_rdata_i(data_rdata_i)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    aluop_i = EXE_NOP_OP; mem_addr_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
    wdata_i = '0; inst_valid_i = 1'b0; inst_pc_i = '0; excepttype_i = '0; flush_i = 1'b0;
    data_ack_i = 1'b0; data_rdata_i = '0;
  endtask
  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] exc, input logic fl);
    aluop_i = op; mem_addr_i = addr; reg2_i = data; wd_i = 5'd9; wreg_i = 1'b1;
    wdata_i = 32'h1234_5678; inst_valid_i = 1'b1; inst_pc_i = 32'h1c00_0000 | addr;
    excepttype_i = exc; flush_i = fl;
  endtask
  // Aligned access: drive, answer the request after dly REQ cycles, optionally pulse flush.
  task automatic access(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int dly,
                        input int fl, input logic [3:0] e_be, input logic [31:0] e_mw,
                        input logic e_wreg, input logic [31:0] e_wdata, input int e_stall);
    exp_t e;
    int stalls, reqn;
    bit done;
    sb.push_back('{wreg: e_wreg, valid: (fl < 0), ale: 1'b0, wdata: e_wdata, stall: e_stall});
    drive(op, addr, data, 2'b00, 1'b0);
    #1;
    stalls = 0; reqn = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      data_ack_i = 1'b0;
      flush_i = 1'b0;
      if (data_req_o) begin
        if (reqn == 0) begin
          check({nm, ".be"}, 32'(data_be_o), 32'(e_be));
          check({nm, ".addr"}, data_addr_o, addr & 32'hffff_fffc);
          check({nm, ".mwdata"}, data_wdata_o, e_mw);
          check({nm, ".we"}, 32'(data_we_o), 32'(is_store(op)));
        end
        if (reqn == fl) flush_i = 1'b1;
        if (reqn >= dly) begin data_ack_i = 1'b1; data_rdata_i = rdata; end
        reqn++;
      end
      if (stallreq_o) stalls++;
      else begin
        e = sb.pop_front();
        check({nm, ".stall"}, 32'(stalls), 32'(e.stall));
        check({nm, ".wreg"}, 32'(wreg_o), 32'(e.wreg));
        check({nm, ".valid"}, 32'(inst_valid_o), 32'(e.valid));
        if (e.wreg) check({nm, ".wdata"}, wdata_o, e.wdata);
        done = 1;
      end
    end
    if (!done) begin
      void'(sb.pop_front());
      check({nm, ".timeout"}, 32'd0, 32'd1);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask
  // Zero-latency cases: result visible in the same cycle, never a request or stall.
  task automatic zl(input string nm, input logic [7:0] op, input logic [31:0] addr,
                    input logic [1:0] exc, input logic fl, input logic e_ale, input logic e_wreg);
    exp_t e;
    sb.push_back('{wreg: e_wreg, valid: 1'b1, ale: e_ale, wdata: 32'h1234_5678, stall: 0});
    drive(op, addr, 32'h0, exc, fl);
    #1;
    e = sb.pop_front();
    check({nm, ".ale"}, 32'(ale_o), 32'(e.ale));
    check({nm, ".wreg"}, 32'(wreg_o), 32'(e.wreg));
    check({nm, ".stall"}, 32'(stallreq_o), 32'(e.stall));
    check({nm, ".wdata"}, wdata_o, e.wdata);
    check({nm, ".pc"}, inst_pc_o, 32'h1c00_0000 | addr);
    check({nm, ".exc"}, 32'(excepttype_o), 32'(exc));
    @(negedge clk); #1;
    check({nm, ".noreq"}, 32'(data_req_o), 32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask
  initial begin
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    drive(EXE_LD_W_OP, 32'h2000, 32'h0, 2'b00, 1'b0);
    #1;
    check("rst.req", 32'(data_req_o), 32'd0);
    check("rst.stall", 32'(stallreq_o), 32'd0);
    check("rst.wreg", 32'(wreg_o), 32'd0);
    check("rst.wdata", wdata_o, 32'd0);
    check("rst.pc", inst_pc_o, 32'd0);
    check("rst.valid", 32'(inst_valid_o), 32'd0);
    check("rst.be", 32'(data_be_o), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    access("stw",  EXE_ST_W_OP,  32'h1000, 32'hdead_beef, 32'h0, 0, -1, 4'hf, 32'hdead_beef, 1'b0, 32'h0, 2);
    access("stb",  EXE_ST_B_OP,  32'h1003, 32'h0000_00a5, 32'h0, 0, -1, 4'h8, 32'ha5a5_a5a5, 1'b0, 32'h0, 2);
    access("sth",  EXE_ST_H_OP,  32'h1002, 32'h1234_beef, 32'h0, 1, -1, 4'hc, 32'hbeef_beef, 1'b0, 32'h0, 3);
    access("ldb",  EXE_LD_B_OP,  32'h2001, 32'h0, 32'h0000_80ff, 0, -1, 4'h2, 32'h0, 1'b1, 32'hffff_ff80, 2);
    access("ldbu", EXE_LD_BU_OP, 32'h2001, 32'h0, 32'h0000_80ff, 0, -1, 4'h2, 32'h0, 1'b1, 32'h0000_0080, 2);
    access("ldh",  EXE_LD_H_OP,  32'h2002, 32'h0, 32'h8001_1234, 0, -1, 4'hc, 32'h0, 1'b1, 32'hffff_8001, 2);
    access("ldhu", EXE_LD_HU_OP, 32'h2000, 32'h0, 32'h8001_f234, 0, -1, 4'h3, 32'h0, 1'b1, 32'h0000_f234, 2);
    access("ldw",  EXE_LD_W_OP,  32'h2004, 32'h0, 32'hcafe_f00d, 2, -1, 4'hf, 32'h0, 1'b1, 32'hcafe_f00d, 4);
    access("ldhfl", EXE_LD_H_OP, 32'h2000, 32'h0, 32'h0000_7fff, 5, 1, 4'h3, 32'h0, 1'b0, 32'h0, 7);
    zl("misw", EXE_LD_W_OP, 32'h2002, 2'b00, 1'b0, 1'b1, 1'b0);
    zl("mish", EXE_LD_H_OP, 32'h2001, 2'b00, 1'b0, 1'b1, 1'b0);
    zl("missh", EXE_ST_H_OP, 32'h1001, 2'b00, 1'b0, 1'b1, 1'b0);
    zl("exc", EXE_LD_W_OP, 32'h2000, 2'b10, 1'b0, 1'b0, 1'b0);
    zl("flidle", EXE_LD_W_OP, 32'h2000, 2'b00, 1'b1, 1'b0, 1'b0);
    zl("add", EXE_ADD_OP, 32'h0040, 2'b00, 1'b0, 1'b0, 1'b1);
    drive(EXE_ADD_OP, 32'h0, 32'h0, 2'b00, 1'b0);
    data_ack_i = 1'b1;
    @(negedge clk); #1;
    check("ackidle.req", 32'(data_req_o), 32'd0);
    check("ackidle.stall", 32'(stallreq_o), 32'd0);
    idle_inputs();
    @(negedge clk);
    drive(EXE_LD_W_OP, 32'h3000, 32'h0, 2'b00, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    check("rstreq.req", 32'(data_req_o), 32'd1);
    rst = 1'b0;
    #1;
    check("rstreq.reqdrop", 32'(data_req_o), 32'd0);
    check("rstreq.stalldrop", 32'(stallreq_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(EXE_ADD_OP, 32'h0, 32'h0, 2'b00, 1'b0);
    #1;
    check("post.stall", 32'(stallreq_o), 32'd0);
    check("post.wreg", 32'(wreg_o), 32'd1);
    check("post.wdata", wdata_o, 32'h1234_5678);
    check("post.wd", 32'(wd_o), 32'd9);
    @(negedge clk); #1;
    check("post.noreq", 32'(data_req_o), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
